// File: rtl/ether_tx_dma.sv
// Transmit DMA engine: pops TX descriptors, fetches frame words from memory
// and streams them to the MAC FIFO with first/last framing and a tag.
module ether_tx_dma #(
    parameter int unsigned CREDITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [27:0] TXdmaAddr,
    input  logic        TXdmaEmpty,
    output logic        readTXdmaAddr,
    input  logic [26:0] TXdmaLength,
    output logic        readTXdmaLength,
    output logic        memReq,
    output logic [27:0] memAddr,
    input  logic        memGrant,
    input  logic        memRdValid,
    input  logic [31:0] memRdData,
    output logic [31:0] txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        txFirst,
    output logic        txLast,
    output logic [1:0]  txLastBytes,
    output logic [15:0] txTag,
    output logic        busy,
    output logic [15:0] framesSent,
    output logic [7:0]  framesDropped
);
    localparam int unsigned PW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam int unsigned CW = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state, stateNext;
    logic [27:0]   baseAddr;
    logic [9:0]    wordCount, reqCount, sentCount, loadWords;
    logic [11:0]   lenPlus3;
    logic [10:0]   lenBytes;
    logic [CW-1:0] inflight, fifoCount;
    logic [PW-1:0] wrPtr, rdPtr, wrPtrNext, rdPtrNext;
    logic [31:0]   fifoMem [CREDITS];
    logic          grant, xfer, accept, lastWord;

    assign lenBytes  = TXdmaLength[10:0];
    assign lenPlus3  = {1'b0, lenBytes} + 12'd3;
    assign loadWords = lenPlus3[11:2];

    assign grant    = memReq & memGrant;
    assign xfer     = txValid & txReady;
    // Only words actually owed by memory are accepted; strays are dropped.
    assign accept   = memRdValid && (inflight > fifoCount);
    assign lastWord = (sentCount == wordCount - 10'd1);

    assign wrPtrNext = (wrPtr == PW'(CREDITS - 1)) ? '0 : wrPtr + PW'(1);
    assign rdPtrNext = (rdPtr == PW'(CREDITS - 1)) ? '0 : rdPtr + PW'(1);

    always_comb begin
        stateNext     = state;
        readTXdmaAddr = 1'b0;
        memReq        = 1'b0;
        case (state)
            IDLE: if (!TXdmaEmpty) stateNext = LOAD;
            LOAD: begin
                readTXdmaAddr = 1'b1;
                stateNext     = (lenBytes == '0) ? IDLE : RUN;
            end
            RUN: begin
                memReq = (reqCount < wordCount) && (inflight < CW'(CREDITS));
                if (xfer && lastWord) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign readTXdmaLength = readTXdmaAddr;
    assign memAddr         = memReq ? (baseAddr + 28'(reqCount)) : '0;
    assign txValid         = (fifoCount != '0);
    assign txData          = txValid ? fifoMem[rdPtr] : '0;
    assign txFirst         = txValid && (sentCount == '0);
    assign txLast          = txValid && lastWord;
    assign busy            = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            baseAddr      <= '0;
            wordCount     <= '0;
            reqCount      <= '0;
            sentCount     <= '0;
            txLastBytes   <= '0;
            txTag         <= '0;
            inflight      <= '0;
            fifoCount     <= '0;
            wrPtr         <= '0;
            rdPtr         <= '0;
            framesSent    <= '0;
            framesDropped <= '0;
        end else begin
            state <= stateNext;
            if (state == LOAD) begin
                baseAddr    <= TXdmaAddr;
                wordCount   <= loadWords;
                txLastBytes <= lenBytes[1:0];
                txTag       <= TXdmaLength[26:11];
                reqCount    <= '0;
                sentCount   <= '0;
                if (lenBytes == '0) framesDropped <= framesDropped + 8'd1;
            end
            if (grant) reqCount <= reqCount + 10'd1;
            if (xfer) begin
                sentCount <= sentCount + 10'd1;
                rdPtr     <= rdPtrNext;
            end
            if (accept) wrPtr <= wrPtrNext;
            case ({grant, xfer})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            case ({accept, xfer})
                2'b10:   fifoCount <= fifoCount + CW'(1);
                2'b01:   fifoCount <= fifoCount - CW'(1);
                default: fifoCount <= fifoCount;
            endcase
            if (state == DONE) framesSent <= framesSent + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) fifoMem[wrPtr] <= memRdData;
    end

endmodule

// File: tb/tb_ether_tx_dma.sv
// Directed and randomized bench for ether_tx_dma with descriptor, memory
// and MAC models plus a frame-level scoreboard.
module tb_ether_tx_dma;
    logic        clock = 1'b0;
    logic        reset;
    logic [27:0] TXdmaAddr;
    logic        TXdmaEmpty;
    logic        readTXdmaAddr;
    logic [26:0] TXdmaLength;
    logic        readTXdmaLength;
    logic        memReq;
    logic [27:0] memAddr;
    logic        memGrant;
    logic        memRdValid;
    logic [31:0] memRdData;
    logic [31:0] txData;
    logic        txValid;
    logic        txReady;
    logic        txFirst;
    logic        txLast;
    logic [1:0]  txLastBytes;
    logic [15:0] txTag;
    logic        busy;
    logic [15:0] framesSent;
    logic [7:0]  framesDropped;

    ether_tx_dma #(.CREDITS(8)) dut (
        .clock(clock), .reset(reset),
        .TXdmaAddr(TXdmaAddr), .TXdmaEmpty(TXdmaEmpty), .readTXdmaAddr(readTXdmaAddr),
        .TXdmaLength(TXdmaLength), .readTXdmaLength(readTXdmaLength),
        .memReq(memReq), .memAddr(memAddr), .memGrant(memGrant),
        .memRdValid(memRdValid), .memRdData(memRdData),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .txFirst(txFirst), .txLast(txLast), .txLastBytes(txLastBytes), .txTag(txTag),
        .busy(busy), .framesSent(framesSent), .framesDropped(framesDropped)
    );

    always #5 clock = ~clock;

    typedef struct { logic [27:0] addr; logic [10:0] len; logic [15:0] tag; } desc_t;
    typedef struct { logic [31:0] data; logic first; logic last; logic [1:0] lastBytes; logic [15:0] tag; } word_t;
    typedef struct { logic [27:0] addr; int due; } rd_t;

    desc_t       descQ[$];
    logic [27:0] expReqQ[$];
    word_t       expTxQ[$];
    rd_t         rdPipe[$];

    int checks = 0, failures = 0, cycle = 0;
    int grants = 0, xfers = 0, pops = 0;
    int popCycle = -1, prevPopCycle = -1, lastTxCycle = -100, gapAtPop = 0;
    int firstReqCycle = -1, firstRdCycle = -1, firstValidCycle = -1, firstTxCycle = -1;
    logic anyReq = 1'b0, anyValid = 1'b0;
    logic [15:0] expSent = '0;
    logic [7:0]  expDropped = '0;
    int readyMode = 1;
    logic grantRandom = 1'b0, latRandom = 1'b0;

    function automatic logic [31:0] memWord(input logic [27:0] a);
        return {4'h0, a} * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic driveDesc();
        TXdmaEmpty = (descQ.size() == 0);
        if (descQ.size() != 0) begin
            TXdmaAddr   = descQ[0].addr;
            TXdmaLength = {descQ[0].tag, descQ[0].len};
        end else begin
            TXdmaAddr   = '0;
            TXdmaLength = '0;
        end
    endtask

    task automatic pushDesc(input logic [27:0] a, input logic [10:0] l, input logic [15:0] t);
        desc_t d;
        d.addr = a; d.len = l; d.tag = t;
        descQ.push_back(d);
        driveDesc();
    endtask

    // Frame-level expectation: ceil(bytes/4) consecutive words, wrapping at 2^28.
    task automatic modelPop(input desc_t d);
        int n;
        logic [27:0] a;
        word_t w;
        if (d.len == 0) begin
            expDropped++;
        end else begin
            n = (int'(d.len) + 3) / 4;
            for (int i = 0; i < n; i++) begin
                a = d.addr + 28'(i);
                expReqQ.push_back(a);
                w.data = memWord(a);
                w.first = (i == 0);
                w.last = (i == n - 1);
                w.lastBytes = 2'(int'(d.len) % 4);
                w.tag = d.tag;
                expTxQ.push_back(w);
            end
        end
    endtask

    task automatic tick();
        desc_t d;
        word_t w;
        rd_t r;
        @(negedge clock);
        if (readTXdmaAddr) begin
            chk("popPair", 64'(readTXdmaLength), 64'(1'b1));
            chk("popAvail", 64'(descQ.size() != 0), 64'(1'b1));
            pops++;
            gapAtPop = cycle - lastTxCycle;
            prevPopCycle = popCycle;
            popCycle = cycle;
            if (descQ.size() != 0) begin
                d = descQ.pop_front();
                modelPop(d);
            end
        end
        if (memReq) begin
            anyReq = 1'b1;
            if (firstReqCycle < 0) firstReqCycle = cycle;
        end
        if (memReq && memGrant) begin
            grants++;
            chk("reqAvail", 64'(expReqQ.size() != 0), 64'(1'b1));
            if (expReqQ.size() != 0) chk("reqAddr", 64'(memAddr), 64'(expReqQ.pop_front()));
            r.addr = memAddr;
            r.due = cycle + 1 + (latRandom ? int'($urandom_range(0, 3)) : 0);
            rdPipe.push_back(r);
        end
        if (memRdValid && firstRdCycle < 0) firstRdCycle = cycle;
        if (txValid) begin
            anyValid = 1'b1;
            if (firstValidCycle < 0) firstValidCycle = cycle;
        end
        if (txValid && txReady) begin
            xfers++;
            if (firstTxCycle < 0) firstTxCycle = cycle;
            chk("txAvail", 64'(expTxQ.size() != 0), 64'(1'b1));
            if (expTxQ.size() != 0) begin
                w = expTxQ.pop_front();
                chk("txData", 64'(txData), 64'(w.data));
                chk("txFirst", 64'(txFirst), 64'(w.first));
                chk("txLast", 64'(txLast), 64'(w.last));
                chk("txTag", 64'(txTag), 64'(w.tag));
                if (w.last) begin
                    chk("txLastBytes", 64'(txLastBytes), 64'(w.lastBytes));
                    expSent++;
                    lastTxCycle = cycle;
                end
            end
        end
        @(posedge clock);
        cycle++;
        #1;
        driveDesc();
        memGrant = memReq && (!grantRandom || $urandom_range(0, 3) != 0);
        if (rdPipe.size() != 0 && rdPipe[0].due <= cycle) begin
            r = rdPipe.pop_front();
            memRdValid = 1'b1;
            memRdData = memWord(r.addr);
        end else begin
            memRdValid = 1'b0;
            memRdData = $urandom;
        end
        txReady = (readyMode == 1) ? 1'b1 : (readyMode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
    endtask

    task automatic runIdle(input int budget);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (descQ.size() == 0 && !busy && expTxQ.size() == 0 && rdPipe.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("idleTimeout", 64'(done), 64'(1'b1));
    endtask

    task automatic armTiming();
        firstReqCycle = -1; firstRdCycle = -1; firstValidCycle = -1; firstTxCycle = -1;
        anyReq = 1'b0; anyValid = 1'b0;
    endtask

    task automatic checkZero();
        chk("rstReadAddr", 64'(readTXdmaAddr), 64'(0));
        chk("rstReadLen", 64'(readTXdmaLength), 64'(0));
        chk("rstMemReq", 64'(memReq), 64'(0));
        chk("rstMemAddr", 64'(memAddr), 64'(0));
        chk("rstTxData", 64'(txData), 64'(0));
        chk("rstTxValid", 64'(txValid), 64'(0));
        chk("rstTxFirst", 64'(txFirst), 64'(0));
        chk("rstTxLast", 64'(txLast), 64'(0));
        chk("rstLastBytes", 64'(txLastBytes), 64'(0));
        chk("rstTag", 64'(txTag), 64'(0));
        chk("rstBusy", 64'(busy), 64'(0));
        chk("rstSent", 64'(framesSent), 64'(0));
        chk("rstDropped", 64'(framesDropped), 64'(0));
    endtask

    int g0, x0, pushCycle, nw;
    int lens[3] = '{61, 5, 1};
    logic [10:0] rl;

    initial begin
        reset = 1'b1; TXdmaEmpty = 1'b1; TXdmaAddr = '0; TXdmaLength = '0;
        memGrant = 1'b0; memRdValid = 1'b0; memRdData = '0; txReady = 1'b1;
        repeat (3) tick();
        checkZero();
        reset = 1'b0;

        // 64-byte frame, continuous memory and MAC
        armTiming(); g0 = grants; x0 = xfers;
        pushDesc(28'h0000100, 11'd64, 16'h00A5);
        pushCycle = cycle;
        runIdle(200);
        chk("t1PopCycle", 64'(popCycle), 64'(pushCycle + 1));
        chk("t1FirstReq", 64'(firstReqCycle), 64'(popCycle + 1));
        chk("t1FirstValid", 64'(firstValidCycle), 64'(firstRdCycle + 1));
        chk("t1Grants", 64'(grants - g0), 64'(16));
        chk("t1Xfers", 64'(xfers - x0), 64'(16));
        chk("t1Throughput", 64'(lastTxCycle - firstTxCycle), 64'(15));
        chk("t1Sent", 64'(framesSent), 64'(1));

        // odd lengths: partial last word and single-word frame
        foreach (lens[i]) begin
            g0 = grants; x0 = xfers;
            nw = (lens[i] + 3) / 4;
            pushDesc(28'($urandom), 11'(lens[i]), 16'($urandom));
            runIdle(200);
            chk("oddGrants", 64'(grants - g0), 64'(nw));
            chk("oddXfers", 64'(xfers - x0), 64'(nw));
        end
        chk("oddSent", 64'(framesSent), 64'(4));

        // zero-length descriptors back to back
        armTiming();
        pushDesc(28'h0000200, 11'd0, 16'h1111);
        pushDesc(28'h0000300, 11'd0, 16'h2222);
        runIdle(50);
        chk("zeroPopSpacing", 64'(popCycle - prevPopCycle), 64'(2));
        chk("zeroNoReq", 64'(anyReq), 64'(0));
        chk("zeroNoValid", 64'(anyValid), 64'(0));
        chk("zeroDropped", 64'(framesDropped), 64'(2));

        // MAC backpressure on a 256-byte frame
        readyMode = 0; txReady = 1'b0;
        g0 = grants; x0 = xfers;
        pushDesc(28'h0004000, 11'd256, 16'h1234);
        repeat (30) tick();
        chk("bpGrants", 64'(grants - g0), 64'(8));
        chk("bpReqLow", 64'(memReq), 64'(0));
        chk("bpNoXfer", 64'(xfers - x0), 64'(0));
        readyMode = 1; txReady = 1'b1;
        runIdle(400);
        chk("bpXfers", 64'(xfers - x0), 64'(64));

        // back-to-back descriptors around the address wrap
        pushDesc(28'hFFFFFFF, 11'd8, 16'hAAAA);
        pushDesc(28'h0000000, 11'd12, 16'h5555);
        runIdle(200);
        chk("b2bGap", 64'(gapAtPop), 64'(3));
        chk("b2bSent", 64'(framesSent), 64'(expSent));

        // reset in the middle of a frame
        pushDesc(28'h0008000, 11'd64, 16'hBEEF);
        pushDesc(28'h000C000, 11'd20, 16'h0F0F);
        x0 = xfers;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (xfers - x0 >= 5) break;
        end
        chk("rmReached", 64'(xfers - x0), 64'(5));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expReqQ.delete(); expTxQ.delete(); rdPipe.delete();
        memRdValid = 1'b0; memGrant = 1'b0;
        expSent = '0; expDropped = '0;
        checkZero();
        runIdle(200);
        chk("rmSent", 64'(framesSent), 64'(1));
        chk("rmDropped", 64'(framesDropped), 64'(0));

        // randomized descriptors, grants, latency and MAC readiness
        grantRandom = 1'b1; latRandom = 1'b1; readyMode = 2;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 3; k++) begin
                rl = ($urandom_range(0, 5) == 0) ? 11'd0 : 11'($urandom_range(1, 160));
                pushDesc(28'($urandom), rl, 16'($urandom));
            end
            runIdle(3000);
        end
        chk("rndSent", 64'(framesSent), 64'(expSent));
        chk("rndDropped", 64'(framesDropped), 64'(expDropped));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
